branch_predict_ctrl: RTL and testbench

- Fetch-stage next-PC controller. It consumes the early-decode flags and immediate of the instruction being fetched and produces a predicted taken flag and target in the same cycle.
- It owns two state structures:
  - a branch history table (BHT) of 2-bit saturating counters, trained from EX;
  - a return address stack (RAS) for call/return prediction.
- It sits between the early instruction decoder and the PC register.

---
 rtl/branch_predict_ctrl.sv | 135 +++++++++++++
 tb/tb_branch_predict_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_ctrl.sv
// Fetch-stage next-PC controller: BHT of 2-bit counters trained from EX,
// plus a circular return address stack for call/return prediction.
module branch_predict_ctrl #(
   parameter int unsigned BHT_AW    = 6,
   parameter int unsigned RAS_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         if_valid,
   input  logic                         if_stall,
   input  logic [31:0]                  if_pc,
   input  logic                         jal,
   input  logic                         jalr,
   input  logic                         B_type,
   input  logic [4:0]                   Rd,
   input  logic [4:0]                   Rs1,
   input  logic [31:0]                  imme,
   output logic                         pred_taken,
   output logic [31:0]                  pred_pc,
   input  logic                         ex_upd_valid,
   input  logic [31:0]                  ex_pc,
   input  logic                         ex_taken,
   output logic [$clog2(RAS_DEPTH):0]   ras_count
);

   localparam int unsigned BHT_N  = 1 << BHT_AW;
   localparam int unsigned RAS_PW = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W  = RAS_PW + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

   function automatic logic is_link(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

   logic [1:0]        bht_q [BHT_N];
   logic [1:0]        bht_cur;
   logic [1:0]        bht_nxt;
   logic [BHT_AW-1:0] if_idx;
   logic [BHT_AW-1:0] ex_idx;

   logic [31:0]       ras_q [RAS_DEPTH];
   logic [31:0]       ras_d [RAS_DEPTH];
   logic [RAS_PW-1:0] ptr_q, ptr_d, ptr_m1;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [31:0]       pc_plus4;
   logic [31:0]       pc_br;
   logic              is_call;
   logic              is_ret;
   logic              ras_nonempty;
   logic              unused_ex_pc_bits;

   assign if_idx            = if_pc[BHT_AW+1:2];
   assign ex_idx            = ex_pc[BHT_AW+1:2];
   assign unused_ex_pc_bits = ^{ex_pc[31:BHT_AW+2], ex_pc[1:0]};
   assign pc_plus4          = if_pc + 32'd4;
   assign pc_br             = if_pc + imme;
   assign ptr_m1            = ptr_q - RAS_PW'(1);
   assign ras_nonempty      = (cnt_q != '0);
   assign ras_count         = cnt_q;

   // A link-to-link jalr with distinct registers is both a return and a call,
   // so it predicts from the stack and then replaces the top.
   assign is_call = (jal | jalr) && is_link(Rd);
   assign is_ret  = jalr && is_link(Rs1) &&
                    ((Rd == 5'd0) || (is_link(Rd) && (Rd != Rs1)));

   always_comb begin
      pred_taken = 1'b0;
      pred_pc    = pc_plus4;
      if (if_valid) begin
         if (jal) begin
            pred_taken = 1'b1;
            pred_pc    = pc_br;
         end else if (is_ret && ras_nonempty) begin
            pred_taken = 1'b1;
            pred_pc    = ras_q[ptr_m1];
         end else if (jalr) begin
            pred_taken = 1'b0;
         end else if (B_type && bht_q[if_idx][1]) begin
            pred_taken = 1'b1;
            pred_pc    = pc_br;
         end
      end
   end

   always_comb begin
      bht_cur = bht_q[ex_idx];
      bht_nxt = bht_cur;
      if (ex_taken) begin
         if (bht_cur != 2'b11) bht_nxt = bht_cur + 2'd1;
      end else begin
         if (bht_cur != 2'b00) bht_nxt = bht_cur - 2'd1;
      end
   end

   always_comb begin
      ras_d = ras_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (if_valid && !if_stall) begin
         if (is_call && is_ret && ras_nonempty) begin
            ras_d[ptr_m1] = pc_plus4;
         end else if (is_call) begin
            ras_d[ptr_q] = pc_plus4;
            ptr_d        = ptr_q + RAS_PW'(1);
            if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
         end else if (is_ret && ras_nonempty) begin
            ptr_d = ptr_m1;
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
      end else if (ex_upd_valid) begin
         bht_q[ex_idx] <= bht_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ras_q <= ras_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: directed vector table, multi-cycle sequences,
// and random traffic checked against a queue/array reference model.
module tb_branch_predict_ctrl;

   localparam int unsigned BHT_AW    = 6;
   localparam int unsigned RAS_DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid, if_stall;
   logic [31:0] if_pc;
   logic        jal, jalr, B_type;
   logic [4:0]  Rd, Rs1;
   logic [31:0] imme;
   logic        pred_taken;
   logic [31:0] pred_pc;
   logic        ex_upd_valid;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [3:0]  ras_count;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   branch_predict_ctrl #(.BHT_AW(BHT_AW), .RAS_DEPTH(RAS_DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_stall(if_stall),
      .if_pc(if_pc), .jal(jal), .jalr(jalr), .B_type(B_type), .Rd(Rd), .Rs1(Rs1),
      .imme(imme), .pred_taken(pred_taken), .pred_pc(pred_pc),
      .ex_upd_valid(ex_upd_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
      .ras_count(ras_count)
   );

   typedef struct {
      logic v; logic st; logic [31:0] pc; logic j; logic jr; logic b;
      logic [4:0] rd; logic [4:0] rs1; logic [31:0] imm;
      logic upd; logic [31:0] xpc; logic xt;
      logic e_t; logic [31:0] e_pc; int e_cnt;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic st, input logic [31:0] pc,
                               input logic j, input logic jr, input logic b,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm,
                               input logic upd, input logic [31:0] xpc, input logic xt,
                               input logic e_t, input logic [31:0] e_pc, input int e_cnt);
      vec_t x;
      x.v = v; x.st = st; x.pc = pc; x.j = j; x.jr = jr; x.b = b;
      x.rd = rd; x.rs1 = rs1; x.imm = imm; x.upd = upd; x.xpc = xpc; x.xt = xt;
      x.e_t = e_t; x.e_pc = e_pc; x.e_cnt = e_cnt;
      return x;
   endfunction

   function automatic vec_t idle(input int e_cnt);
      return mk(0, 0, 32'h0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 0, 32'h0, 0, 0, 32'h4, e_cnt);
   endfunction

   function automatic vec_t upd(input logic t, input int e_cnt);
      return mk(0, 0, 32'h0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 1, 32'h100, t, 0, 32'h4, e_cnt);
   endfunction

   // Reference model: counters as small integers, the RAS as a bounded LIFO queue.
   int unsigned bht_m [64];
   logic [31:0] ras_m [$];

   function automatic logic link(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

   function automatic void model_reset();
      foreach (bht_m[i]) bht_m[i] = 1;
      ras_m.delete();
   endfunction

   function automatic void model_pred(input vec_t x, output logic t, output logic [31:0] p);
      logic pure_ret, swap;
      int   idx;
      pure_ret = x.jr && x.rd == 5'd0 && link(x.rs1);
      swap     = x.jr && link(x.rd) && link(x.rs1) && x.rd != x.rs1;
      idx      = int'(x.pc[7:2]);
      t = 1'b0;
      p = x.pc + 32'd4;
      if (x.v) begin
         if (x.j) begin
            t = 1'b1; p = x.pc + x.imm;
         end else if ((pure_ret || swap) && ras_m.size() > 0) begin
            t = 1'b1; p = ras_m[$];
         end else if (x.jr) begin
            t = 1'b0;
         end else if (x.b && bht_m[idx] >= 2) begin
            t = 1'b1; p = x.pc + x.imm;
         end
      end
   endfunction

   function automatic void model_update(input vec_t x);
      logic call, pure_ret, swap;
      int   k;
      if (x.upd) begin
         k = int'(x.xpc[7:2]);
         if (x.xt && bht_m[k] < 3) bht_m[k]++;
         else if (!x.xt && bht_m[k] > 0) bht_m[k]--;
      end
      if (x.v && !x.st) begin
         call     = (x.j || x.jr) && link(x.rd);
         pure_ret = x.jr && x.rd == 5'd0 && link(x.rs1);
         swap     = x.jr && link(x.rd) && link(x.rs1) && x.rd != x.rs1;
         if (swap && ras_m.size() > 0) begin
            ras_m[$] = x.pc + 32'd4;
         end else if (call) begin
            if (ras_m.size() == RAS_DEPTH) void'(ras_m.pop_front());
            ras_m.push_back(x.pc + 32'd4);
         end else if (pure_ret && ras_m.size() > 0) begin
            void'(ras_m.pop_back());
         end
      end
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t x);
      if_valid = x.v; if_stall = x.st; if_pc = x.pc;
      jal = x.j; jalr = x.jr; B_type = x.b; Rd = x.rd; Rs1 = x.rs1; imme = x.imm;
      ex_upd_valid = x.upd; ex_pc = x.xpc; ex_taken = x.xt;
   endtask

   task automatic run(input vec_t x, input string tag);
      drive(x);
      @(negedge clk);
      check({tag, ".taken"}, {31'b0, pred_taken}, {31'b0, x.e_t});
      check({tag, ".pc"}, pred_pc, x.e_pc);
      check({tag, ".cnt"}, {28'b0, ras_count}, 32'(x.e_cnt));
      @(posedge clk);
      model_update(x);
      #1;
   endtask

   task automatic do_reset();
      drive(idle(0));
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   function automatic logic [4:0] pick_reg();
      case ($urandom_range(0, 3))
         0:       return 5'd0;
         1:       return 5'd1;
         2:       return 5'd5;
         default: return 5'($urandom_range(0, 31));
      endcase
   endfunction

   vec_t tbl [$];

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t x;
      vec_t bf;

      drive(idle(0));
      rst_n = 1'b0;
      model_reset();
      #12;
      drive(mk(1, 0, 32'h100, 0, 0, 1, 5'd0, 5'd0, 32'h20, 0, 32'h0, 0, 0, 32'h104, 0));
      #1;
      check("reset.cnt", {28'b0, ras_count}, 32'h0);
      check("reset.taken", {31'b0, pred_taken}, 32'h0);
      check("reset.pc", pred_pc, 32'h104);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Counter trajectory for 0x100: 01,10,11,11,11,10,01,00,00,01
      bf = mk(1, 0, 32'h100, 0, 0, 1, 5'd0, 5'd0, 32'h20, 0, 32'h0, 0, 0, 32'h104, 0);
      tbl.push_back(bf);
      tbl.push_back(upd(1, 0));
      tbl.push_back(upd(1, 0));
      x = bf; x.e_t = 1; x.e_pc = 32'h120; tbl.push_back(x);
      tbl.push_back(upd(1, 0));
      tbl.push_back(upd(1, 0));
      tbl.push_back(upd(0, 0));
      tbl.push_back(x);
      tbl.push_back(upd(0, 0));
      tbl.push_back(bf);
      tbl.push_back(upd(0, 0));
      tbl.push_back(upd(0, 0));
      tbl.push_back(upd(1, 0));
      tbl.push_back(bf);
      tbl.push_back(mk(1, 0, 32'h200, 1, 0, 0, 5'd1, 5'd0, 32'h400, 0, 32'h0, 0, 1, 32'h600, 0));
      tbl.push_back(idle(1));
      tbl.push_back(mk(1, 0, 32'h604, 0, 1, 0, 5'd0, 5'd1, 32'h0, 0, 32'h0, 0, 1, 32'h204, 1));
      tbl.push_back(idle(0));
      tbl.push_back(mk(1, 0, 32'h700, 0, 1, 0, 5'd0, 5'd5, 32'h0, 0, 32'h0, 0, 0, 32'h704, 0));
      tbl.push_back(idle(0));
      tbl.push_back(mk(1, 0, 32'hFFFF_FFF0, 1, 0, 0, 5'd0, 5'd0, 32'h20, 0, 32'h0, 0, 1, 32'h10, 0));
      tbl.push_back(mk(0, 0, 32'hFFFF_FFFC, 0, 0, 0, 5'd0, 5'd0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0));
      tbl.push_back(mk(0, 0, 32'h200, 1, 0, 0, 5'd1, 5'd0, 32'h400, 0, 32'h0, 0, 0, 32'h204, 0));
      tbl.push_back(idle(0));
      tbl.push_back(mk(1, 0, 32'h800, 0, 1, 0, 5'd2, 5'd3, 32'h40, 0, 32'h0, 0, 0, 32'h804, 0));
      foreach (tbl[i]) run(tbl[i], $sformatf("tbl%0d", i));

      // RAS overflow and LIFO drain
      do_reset();
      for (int i = 0; i < 10; i++)
         run(mk(1, 0, 32'h1000 + 32'(i * 16), 1, 0, 0, 5'd1, 5'd0, 32'h100, 0, 32'h0, 0,
                1, 32'h1100 + 32'(i * 16), (i < 8) ? i : 8), $sformatf("ovf.push%0d", i));
      run(idle(8), "ovf.full");
      for (int k = 0; k < 8; k++)
         run(mk(1, 0, 32'h2000, 0, 1, 0, 5'd0, 5'd5, 32'h0, 0, 32'h0, 0,
                1, 32'h1004 + 32'((9 - k) * 16), 8 - k), $sformatf("ovf.pop%0d", k));
      run(mk(1, 0, 32'h2000, 0, 1, 0, 5'd0, 5'd5, 32'h0, 0, 32'h0, 0, 0, 32'h2004, 0), "ovf.pop8");
      run(idle(0), "ovf.empty");

      // Stalled call pushes once; pop-then-push replaces top
      do_reset();
      for (int i = 0; i < 3; i++)
         run(mk(1, 1, 32'h4C, 1, 0, 0, 5'd1, 5'd0, 32'h10, 0, 32'h0, 0, 1, 32'h5C, 0),
             $sformatf("stall%0d", i));
      run(mk(1, 0, 32'h4C, 1, 0, 0, 5'd1, 5'd0, 32'h10, 0, 32'h0, 0, 1, 32'h5C, 0), "stall.rel");
      run(idle(1), "stall.cnt");
      run(mk(1, 0, 32'h300, 0, 1, 0, 5'd1, 5'd5, 32'h0, 0, 32'h0, 0, 1, 32'h50, 1), "swap");
      run(idle(1), "swap.cnt");
      run(mk(1, 0, 32'h400, 0, 1, 0, 5'd0, 5'd1, 32'h0, 0, 32'h0, 0, 1, 32'h304, 1), "swap.top");
      run(idle(0), "swap.drain");
      run(mk(1, 0, 32'h500, 0, 1, 0, 5'd5, 5'd1, 32'h0, 0, 32'h0, 0, 0, 32'h504, 0), "swap.empty");
      run(idle(1), "swap.empty.cnt");
      run(mk(1, 0, 32'h600, 0, 1, 0, 5'd0, 5'd5, 32'h0, 0, 32'h0, 0, 1, 32'h504, 1), "swap.empty.top");

      // Same-cycle BHT read/write, then asynchronous reset mid-operation
      do_reset();
      run(mk(1, 0, 32'h180, 0, 0, 1, 5'd0, 5'd0, 32'h40, 1, 32'h180, 1, 0, 32'h184, 0), "rw.same");
      run(mk(1, 0, 32'h180, 0, 0, 1, 5'd0, 5'd0, 32'h40, 0, 32'h0, 0, 1, 32'h1C0, 0), "rw.next");
      run(mk(1, 0, 32'h900, 1, 0, 0, 5'd5, 5'd0, 32'h8, 0, 32'h0, 0, 1, 32'h908, 0), "rst.call");
      run(idle(1), "rst.pre");
      drive(mk(1, 0, 32'h180, 0, 0, 1, 5'd0, 5'd0, 32'h40, 0, 32'h0, 0, 0, 32'h0, 0));
      #1;
      check("rst.before.taken", {31'b0, pred_taken}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("rst.async.cnt", {28'b0, ras_count}, 32'h0);
      check("rst.async.taken", {31'b0, pred_taken}, 32'h0);
      check("rst.async.pc", pred_pc, 32'h184);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      run(mk(1, 0, 32'h180, 0, 0, 1, 5'd0, 5'd0, 32'h40, 0, 32'h0, 0, 0, 32'h184, 0), "rst.after");

      // Random traffic against the reference model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         int kind;
         x.v   = ($urandom_range(0, 9) != 0);
         x.st  = ($urandom_range(0, 4) == 0);
         x.pc  = ($urandom & 32'h0000_00FC) |
                 (($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FF00) : 32'h0);
         kind  = $urandom_range(0, 5);
         x.j   = (kind == 1) || (kind == 4 && $urandom_range(0, 1) == 1);
         x.jr  = (kind == 2) || (kind == 5) || (kind == 4 && $urandom_range(0, 1) == 1);
         x.b   = (kind == 3) || (kind == 4 && $urandom_range(0, 1) == 1);
         x.rd  = (kind == 5) ? 5'd0 : pick_reg();
         x.rs1 = pick_reg();
         x.imm = $urandom;
         x.upd = ($urandom_range(0, 1) == 1);
         x.xpc = $urandom & 32'h0000_00FC;
         x.xt  = ($urandom_range(0, 1) == 1);
         model_pred(x, x.e_t, x.e_pc);
         x.e_cnt = ras_m.size();
         run(x, $sformatf("rnd%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
